hog_cell_hist_ctrl: RTL and testbench
=====================================

Name: hog_cell_hist_ctrl

Overview:
- Sequences a gradient pixel stream through the calculate_bin pipeline (4-cycle latency) and keeps each pixel's magnitude aligned with its returned bin number.
- Accumulates magnitudes into an 18-bin histogram per cell, then streams the 18 bins out to the block-normalisation stage.
- Sits between the gradient/magnitude stage and the HOG normaliser in hog_mdl.

Parameters:
- TOTAL_BIT_WIDTH, 35, width of dx/dy passed to calculate_bin
- MAG_W, 16, unsigned gradient magnitude width
- CELL_PIXELS, 64, pixels per cell (power of two, 4..256)
- BIN_LATENCY, 4, cycles from dx_dy_valid to bin_num_valid
- ACC_W, 22, histogram accumulator width (MAG_W + log2(CELL_PIXELS) by default)

Ports:
- aclk  in  1  clock
- arest_n  in  1  asynchronous active-low reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid&s_ready
- s_dx  in  TOTAL_BIT_WIDTH  |dx|
- s_dy  in  TOTAL_BIT_WIDTH  |dy|
- s_quadrant  in  2  gradient quadrant 0..3
- s_mag  in  MAG_W  gradient magnitude
- cb_dx, cb_dy  out  TOTAL_BIT_WIDTH  to calculate_bin
- cb_quadrant  out  2  to calculate_bin
- cb_valid  out  1  to calculate_bin dx_dy_valid
- cb_bin_num  in  5  from calculate_bin
- cb_bin_valid  in  1  from calculate_bin
- m_valid  out  1  histogram word valid
- m_ready  in  1  downstream ready
- m_bin  out  5  bin index 0..17
- m_data  out  ACC_W  accumulated magnitude
- m_last  out  1  high on bin 17
- err_bin  out  1  sticky: cb_bin_num >= 18 was received

Behaviour:
- Reset (async, arest_n=0): state ACCUM; all 18 accumulators 0; issue/retire counters 0; s_ready=0 during reset then 1; cb_valid=0, cb_dx/cb_dy/cb_quadrant=0; m_valid=0, m_bin=0, m_data=0, m_last=0; err_bin=0. Reset mid-cell or mid-output discards everything.
- cb_* are registered copies of s_* on handshake; cb_valid = registered (s_valid&s_ready). Total input-to-bin latency = 1 + BIN_LATENCY.
- Magnitude delay line: shift register of depth 1+BIN_LATENCY carrying s_mag with valid; its tail must coincide with cb_bin_valid. Mismatch (cb_bin_valid without tail valid, or vice versa) sets err_bin; accumulation uses tail valid only.
- States:
  - ACCUM: s_ready=1 while issue_cnt < CELL_PIXELS. Each handshake increments issue_cnt. Each aligned retire adds mag to acc[bin] (bin<18) and increments retire_cnt. When issue_cnt reaches CELL_PIXELS, s_ready drops next cycle -> DRAIN.
  - DRAIN: s_ready=0; wait until retire_cnt == CELL_PIXELS (counting discarded bad bins too) -> OUTPUT.
  - OUTPUT: m_valid=1, m_bin walks 0..17, m_data=acc[m_bin]; advance on m_valid&m_ready; m_last=1 at bin 17. On final handshake clear all accumulators and counters in the same cycle -> ACCUM, s_ready=1 next cycle.
- m_* hold stable while m_valid&!m_ready.
- Retire and issue in the same cycle are both counted. Two retires to the same bin in consecutive cycles must both accumulate (read-modify-write forwarding).
- Accumulation wraps modulo 2^ACC_W unless the optional feature is enabled.
- bin >= 18: magnitude dropped, err_bin set, retire_cnt still increments.
- Throughput: 1 pixel/cycle in ACCUM; per cell ≈ CELL_PIXELS + 1 + BIN_LATENCY + 18 cycles when m_ready=1.

Optional Feature:
- HOG_HIST_SAT_EN: defined -> each accumulator add saturates at 2^ACC_W-1, and an output sat_flag (1 bit, reset 0, sticky until the next cell starts) reports saturation in the current cell. Not defined -> modulo add, and sat_flag is absent.

Decomposition:
- Package hog_pkg: NUM_BINS=18, BIN_IDX_W=5, BIN_LATENCY_DEF=4, and a state enum {ACCUM, DRAIN, OUTPUT}.
- Sub-module hog_mag_delay: parameterised valid+data shift register (depth, width). The FSM and histogram register file stay in the top module.

Test Plan:
- 64 pixels quadrant 0, dx=256, dy=0, mag=10, m_ready=1 -> bin0=640, all other bins 0, m_last on bin 17, then s_ready=1 again.
- Alternating bins 4 and 13 with mag=1 on back-to-back cycles, plus a run of 8 consecutive pixels to bin 4 -> bins 4 and 13 exact, no lost updates from forwarding.
- Hold m_ready=0 for 10 cycles at bin 5 -> m_bin, m_data and m_valid stable; s_ready stays 0.
- Force cb_bin_num=18 once among 64 pixels -> err_bin=1, that magnitude is dropped, and the FSM still completes the cell.
- Assert arest_n=0 at retire 30 -> all outputs at reset values; the next cell accumulates from 0.
- With HOG_HIST_SAT_EN, ACC_W=8, 64 pixels of mag=255 to bin 0 -> bin0=255, sat_flag=1.

Source files
------------

// File: rtl/hog_pkg.sv
// Shared constants and FSM state type for the HOG cell histogram controller.
package hog_pkg;

    localparam int NUM_BINS        = 18;
    localparam int BIN_IDX_W       = 5;
    localparam int BIN_LATENCY_DEF = 4;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        OUTPUT = 2'd2
    } hog_state_e;

endpackage

// File: rtl/hog_cell_hist_ctrl_if.sv
// Pixel input, calculate_bin side-channel and histogram output of hog_cell_hist_ctrl.
// sat_flag exists only when HOG_HIST_SAT_EN is defined.
interface hog_cell_hist_ctrl_if #(
    parameter int TOTAL_BIT_WIDTH = 35,
    parameter int MAG_W           = 16,
    parameter int ACC_W           = 22
);
    logic                       s_valid;
    logic                       s_ready;
    logic [TOTAL_BIT_WIDTH-1:0] s_dx;
    logic [TOTAL_BIT_WIDTH-1:0] s_dy;
    logic [1:0]                 s_quadrant;
    logic [MAG_W-1:0]           s_mag;
    logic [TOTAL_BIT_WIDTH-1:0] cb_dx;
    logic [TOTAL_BIT_WIDTH-1:0] cb_dy;
    logic [1:0]                 cb_quadrant;
    logic                       cb_valid;
    logic [4:0]                 cb_bin_num;
    logic                       cb_bin_valid;
    logic                       m_valid;
    logic                       m_ready;
    logic [4:0]                 m_bin;
    logic [ACC_W-1:0]           m_data;
    logic                       m_last;
    logic                       err_bin;
`ifdef HOG_HIST_SAT_EN
    logic                       sat_flag;
`endif

    // Environment side: pixel source, calculate_bin and histogram sink.
    modport master (
        output s_valid, s_dx, s_dy, s_quadrant, s_mag, cb_bin_num, cb_bin_valid, m_ready,
`ifdef HOG_HIST_SAT_EN
        input  sat_flag,
`endif
        input  s_ready, cb_dx, cb_dy, cb_quadrant, cb_valid, m_valid, m_bin, m_data, m_last, err_bin
    );

    modport slave (
        input  s_valid, s_dx, s_dy, s_quadrant, s_mag, cb_bin_num, cb_bin_valid, m_ready,
`ifdef HOG_HIST_SAT_EN
        output sat_flag,
`endif
        output s_ready, cb_dx, cb_dy, cb_quadrant, cb_valid, m_valid, m_bin, m_data, m_last, err_bin
    );

endinterface

// File: rtl/hog_mag_delay.sv
// Valid+data shift register that carries each accepted magnitude until its bin returns.
module hog_mag_delay #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_r [DEPTH];

    // Shift valid and data one stage per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            valid_r[0] <= d_valid;
            data_r[0]  <= d_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign q_valid = valid_r[DEPTH-1];
    assign q_data  = data_r[DEPTH-1];

endmodule

// File: rtl/hog_cell_hist_ctrl.sv
// Per-cell 18-bin gradient histogram: issues pixels to calculate_bin, accumulates
// returned bins, then streams the bins out. Optional saturating add: HOG_HIST_SAT_EN.
module hog_cell_hist_ctrl
    import hog_pkg::*;
#(
    parameter int TOTAL_BIT_WIDTH = 35,
    parameter int MAG_W           = 16,
    parameter int CELL_PIXELS     = 64,
    parameter int BIN_LATENCY     = BIN_LATENCY_DEF,
    parameter int ACC_W           = 22
) (
    input logic                  aclk,
    input logic                  arest_n,
    hog_cell_hist_ctrl_if.slave  bus
);

    localparam int                   CNT_W    = $clog2(CELL_PIXELS + 1);
    localparam logic [CNT_W-1:0]     CELL_CNT = CNT_W'(CELL_PIXELS);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [BIN_IDX_W-1:0] LAST_BIN = BIN_IDX_W'(NUM_BINS - 1);
    localparam logic [BIN_IDX_W-1:0] BIN_ONE  = BIN_IDX_W'(1);
    localparam logic [BIN_IDX_W-1:0] BIN_LIM  = BIN_IDX_W'(NUM_BINS);

    hog_state_e                 state_r;
    logic [CNT_W-1:0]           issue_cnt_r;
    logic [CNT_W-1:0]           retire_cnt_r;
    logic [ACC_W-1:0]           acc_r [NUM_BINS];
    logic                       s_ready_r;
    logic [TOTAL_BIT_WIDTH-1:0] cb_dx_r;
    logic [TOTAL_BIT_WIDTH-1:0] cb_dy_r;
    logic [1:0]                 cb_quadrant_r;
    logic                       cb_valid_r;
    logic                       m_valid_r;
    logic [BIN_IDX_W-1:0]       m_bin_r;
    logic [ACC_W-1:0]           m_data_r;
    logic                       m_last_r;
    logic                       err_bin_r;

    logic                       hs_s;
    logic                       tail_valid_s;
    logic [MAG_W-1:0]           tail_mag_s;
    logic                       bin_ok_s;
    logic                       add_s;
    logic [BIN_IDX_W-1:0]       bin_idx_s;
    logic [ACC_W-1:0]           new_acc_s;
    logic [CNT_W-1:0]           issue_next_s;
    logic [BIN_IDX_W-1:0]       m_bin_next_s;

    assign hs_s         = bus.s_valid & s_ready_r;
    assign bin_ok_s     = (bus.cb_bin_num < BIN_LIM);
    assign add_s        = tail_valid_s & bin_ok_s;
    assign issue_next_s = issue_cnt_r + (hs_s ? CNT_ONE : {CNT_W{1'b0}});
    assign m_bin_next_s = m_bin_r + BIN_ONE;

    // The extra stage covers the cb_* register in front of calculate_bin.
    hog_mag_delay #(
        .DEPTH (1 + BIN_LATENCY),
        .WIDTH (MAG_W)
    ) u_mag_delay (
        .clk     (aclk),
        .rst_n   (arest_n),
        .d_valid (hs_s),
        .d_data  (bus.s_mag),
        .q_valid (tail_valid_s),
        .q_data  (tail_mag_s)
    );

`ifdef HOG_HIST_SAT_EN
    localparam int SUM_W = ((ACC_W > MAG_W) ? ACC_W : MAG_W) + 1;
    logic [SUM_W-1:0] sum_s;
    logic             ovf_s;
    logic             sat_flag_r;
`endif

    // Single-cycle read-modify-write value for the returning bin
    always_comb begin
        bin_idx_s = bin_ok_s ? bus.cb_bin_num : {BIN_IDX_W{1'b0}};
`ifdef HOG_HIST_SAT_EN
        sum_s = SUM_W'(acc_r[bin_idx_s]) + SUM_W'(tail_mag_s);
        ovf_s = |sum_s[SUM_W-1:ACC_W];
        if (ovf_s) begin
            new_acc_s = {ACC_W{1'b1}};
        end else begin
            new_acc_s = sum_s[ACC_W-1:0];
        end
`else
        new_acc_s = acc_r[bin_idx_s] + ACC_W'(tail_mag_s);
`endif
    end

    // Issue register, accumulation, cell FSM and output stream
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            state_r       <= ACCUM;
            issue_cnt_r   <= {CNT_W{1'b0}};
            retire_cnt_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < NUM_BINS; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
            s_ready_r     <= 1'b0;
            cb_dx_r       <= {TOTAL_BIT_WIDTH{1'b0}};
            cb_dy_r       <= {TOTAL_BIT_WIDTH{1'b0}};
            cb_quadrant_r <= 2'd0;
            cb_valid_r    <= 1'b0;
            m_valid_r     <= 1'b0;
            m_bin_r       <= {BIN_IDX_W{1'b0}};
            m_data_r      <= {ACC_W{1'b0}};
            m_last_r      <= 1'b0;
            err_bin_r     <= 1'b0;
`ifdef HOG_HIST_SAT_EN
            sat_flag_r    <= 1'b0;
`endif
        end else begin
            cb_valid_r <= hs_s;
            if (hs_s) begin
                cb_dx_r       <= bus.s_dx;
                cb_dy_r       <= bus.s_dy;
                cb_quadrant_r <= bus.s_quadrant;
            end
            issue_cnt_r <= issue_next_s;
            // Out-of-range bins still retire so the cell always completes
            if (tail_valid_s) begin
                retire_cnt_r <= retire_cnt_r + CNT_ONE;
            end
            if (add_s) begin
                acc_r[bin_idx_s] <= new_acc_s;
            end
            if ((tail_valid_s != bus.cb_bin_valid) || (bus.cb_bin_valid && !bin_ok_s)) begin
                err_bin_r <= 1'b1;
            end
`ifdef HOG_HIST_SAT_EN
            if (add_s && ovf_s) begin
                sat_flag_r <= 1'b1;
            end
`endif
            case (state_r)
                ACCUM: begin
                    s_ready_r <= (issue_next_s < CELL_CNT);
                    if (issue_cnt_r == CELL_CNT) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    s_ready_r <= 1'b0;
                    if (retire_cnt_r == CELL_CNT) begin
                        state_r   <= OUTPUT;
                        m_valid_r <= 1'b1;
                        m_bin_r   <= {BIN_IDX_W{1'b0}};
                        m_data_r  <= acc_r[0];
                        m_last_r  <= 1'b0;
                    end
                end
                OUTPUT: begin
                    s_ready_r <= 1'b0;
                    if (m_valid_r && bus.m_ready) begin
                        if (m_last_r) begin
                            state_r      <= ACCUM;
                            s_ready_r    <= 1'b1;
                            issue_cnt_r  <= {CNT_W{1'b0}};
                            retire_cnt_r <= {CNT_W{1'b0}};
                            for (int i = 0; i < NUM_BINS; i++) begin
                                acc_r[i] <= {ACC_W{1'b0}};
                            end
                            m_valid_r    <= 1'b0;
                            m_bin_r      <= {BIN_IDX_W{1'b0}};
                            m_data_r     <= {ACC_W{1'b0}};
                            m_last_r     <= 1'b0;
`ifdef HOG_HIST_SAT_EN
                            sat_flag_r   <= 1'b0;
`endif
                        end else begin
                            m_bin_r  <= m_bin_next_s;
                            m_data_r <= acc_r[m_bin_next_s];
                            m_last_r <= (m_bin_next_s == LAST_BIN);
                        end
                    end
                end
                default: begin
                    state_r   <= ACCUM;
                    s_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready     = s_ready_r;
    assign bus.cb_dx       = cb_dx_r;
    assign bus.cb_dy       = cb_dy_r;
    assign bus.cb_quadrant = cb_quadrant_r;
    assign bus.cb_valid    = cb_valid_r;
    assign bus.m_valid     = m_valid_r;
    assign bus.m_bin       = m_bin_r;
    assign bus.m_data      = m_data_r;
    assign bus.m_last      = m_last_r;
    assign bus.err_bin     = err_bin_r;
`ifdef HOG_HIST_SAT_EN
    assign bus.sat_flag    = sat_flag_r;
`endif

endmodule

// File: tb/tb_hog_cell_hist_ctrl.sv
// Directed bench for hog_cell_hist_ctrl with a 4-cycle calculate_bin stand-in.
// Builds with or without HOG_HIST_SAT_EN (ACC_W drops to 8 when it is defined).
module tb_hog_cell_hist_ctrl;

    localparam int TBW = 35;
    localparam int MW  = 16;
`ifdef HOG_HIST_SAT_EN
    localparam int AW  = 8;
`else
    localparam int AW  = 22;
`endif
    localparam longint MAXV = (longint'(1) << AW) - 64'sd1;

    logic aclk;
    logic arest_n;

    hog_cell_hist_ctrl_if #(.TOTAL_BIT_WIDTH(TBW), .MAG_W(MW), .ACC_W(AW)) bus ();

    hog_cell_hist_ctrl #(
        .TOTAL_BIT_WIDTH (TBW),
        .MAG_W           (MW),
        .CELL_PIXELS     (64),
        .BIN_LATENCY     (4),
        .ACC_W           (AW)
    ) dut (
        .aclk    (aclk),
        .arest_n (arest_n),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // calculate_bin stand-in: returns dy[4:0] as the bin, 4 cycles after cb_valid
    logic [3:0] pv;
    logic [4:0] pb [4];
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            pv <= 4'd0;
            for (int i = 0; i < 4; i++) pb[i] <= 5'd0;
        end else begin
            pv    <= {pv[2:0], bus.cb_valid};
            pb[0] <= bus.cb_dy[4:0];
            pb[1] <= pb[0];
            pb[2] <= pb[1];
            pb[3] <= pb[2];
        end
    end
    assign bus.cb_bin_valid = pv[3];
    assign bus.cb_bin_num   = pb[3];

    typedef struct {
        string  name;
        int     mode;     // 0 all->a, 1 alt a/b then 8 x a, 2 alt a/b, 3 all->a except pixel 20 -> bin 18
        int     mag;
        int     a;
        int     b;
        longint exp_a;    // unbounded sum expected in bin a
        longint exp_b;
        bit     exp_err;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    longint exp_bins [18];
    bit     exp_sat;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint clip(input longint raw);
`ifdef HOG_HIST_SAT_EN
        if (raw > MAXV) return MAXV;
        return raw;
`else
        return raw & MAXV;
`endif
    endfunction

    function automatic int pix_bin(input int mode, input int a, input int b, input int i);
        case (mode)
            1:       return (i < 56 && (i % 2) == 1) ? b : a;
            2:       return ((i % 2) == 1) ? b : a;
            3:       return (i == 20) ? 18 : a;
            default: return a;
        endcase
    endfunction

    task automatic set_pixel(input int mode, input int a, input int b, input int mag, input int i);
        bus.s_dx       = TBW'(256);
        bus.s_dy       = TBW'(pix_bin(mode, a, b, i));
        bus.s_quadrant = 2'd0;
        bus.s_mag      = MW'(mag);
    endtask

    task automatic feed(input int mode, input int a, input int b, input int mag);
        int i;
        int guard;
        bit take;
        i = 0;
        guard = 0;
        set_pixel(mode, a, b, mag, 0);
        bus.s_valid = 1'b1;
        while (i < 64 && guard < 400) begin
            take = bus.s_ready;
            @(posedge aclk); #1;
            guard++;
            if (take) begin
                i++;
                if (i < 64) set_pixel(mode, a, b, mag, i);
            end
        end
        bus.s_valid = 1'b0;
        chk("feed_accepted", i, 64);
    endtask

    // Drain 18 words against exp_bins; optionally stall 10 cycles on hold_bin
    task automatic collect(input int hold_bin);
        int k;
        int guard;
        k = 0;
        guard = 0;
        bus.m_ready = 1'b1;
        while (k < 18 && guard < 500) begin
            if (bus.m_valid) begin
                if (k == hold_bin) begin
                    bus.m_ready = 1'b0;
                    for (int c = 0; c < 10; c++) begin
                        @(posedge aclk); #1;
                        chk("hold_m_valid", bus.m_valid, 1);
                        chk("hold_m_bin", bus.m_bin, hold_bin);
                        chk("hold_m_data", bus.m_data, clip(exp_bins[hold_bin]));
                        chk("hold_s_ready", bus.s_ready, 0);
                    end
                    bus.m_ready = 1'b1;
                end
                chk("m_bin", bus.m_bin, k);
                chk($sformatf("m_data[%0d]", k), bus.m_data, clip(exp_bins[k]));
                chk("m_last", bus.m_last, (k == 17) ? 1 : 0);
`ifdef HOG_HIST_SAT_EN
                if (k == 0) chk("sat_flag", bus.sat_flag, exp_sat);
`endif
                k++;
            end
            @(posedge aclk); #1;
            guard++;
        end
        chk("collect_words", k, 18);
        chk("after_cell_m_valid", bus.m_valid, 0);
        chk("after_cell_s_ready", bus.s_ready, 1);
`ifdef HOG_HIST_SAT_EN
        chk("after_cell_sat_clear", bus.sat_flag, 0);
`endif
    endtask

    task automatic run_vec(input vec_t v, input int hold_bin);
        exp_sat = 1'b0;
        for (int k = 0; k < 18; k++) begin
            exp_bins[k] = (k == v.a) ? v.exp_a : ((k == v.b) ? v.exp_b : 64'sd0);
            if (exp_bins[k] > MAXV) exp_sat = 1'b1;
        end
        feed(v.mode, v.a, v.b, v.mag);
        collect(hold_bin);
        chk({v.name, "_err_bin"}, bus.err_bin, v.exp_err);
    endtask

    vec_t vecs [6];
    vec_t hold_v;
    int   rcnt;
    int   guard;

    initial begin
        vecs[0] = '{"single_bin0",  0, 10,    0,  1, 640,     0,       1'b0};
        vecs[1] = '{"alt_4_13",     1, 1,     4,  13, 36,     28,      1'b0};
        vecs[2] = '{"alt_0_17_max", 2, 65535, 0,  17, 2097120, 2097120, 1'b0};
        vecs[3] = '{"bin17_1000",   0, 1000,  17, 16, 64000,  0,       1'b0};
        vecs[4] = '{"bin0_255",     0, 255,   0,  1, 16320,   0,       1'b0};
        vecs[5] = '{"bad_bin18",    3, 7,     9,  10, 441,    0,       1'b1};
        hold_v  = '{"hold_bin5",    0, 3,     5,  6, 192,     0,       1'b0};

        arest_n        = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_dx       = '0;
        bus.s_dy       = '0;
        bus.s_quadrant = 2'd0;
        bus.s_mag      = '0;
        bus.m_ready    = 1'b1;
        #12;
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_cb_valid", bus.cb_valid, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_err_bin", bus.err_bin, 0);
        #10;
        arest_n = 1'b1;
        @(posedge aclk); #1;
        chk("post_rst_s_ready", bus.s_ready, 1);

        for (int v = 0; v < 5; v++) run_vec(vecs[v], -1);
        run_vec(hold_v, 5);
        run_vec(vecs[5], -1);

        // Reset while the 30th bin is returning
        rcnt = 0;
        guard = 0;
        set_pixel(0, 0, 0, 10, 0);
        bus.s_valid = 1'b1;
        while (rcnt < 30 && guard < 200) begin
            @(posedge aclk); #1;
            guard++;
            if (bus.cb_bin_valid) rcnt++;
        end
        chk("mid_rst_retires", rcnt, 30);
        arest_n = 1'b0;
        bus.s_valid = 1'b0;
        #2;
        chk("mid_rst_s_ready", bus.s_ready, 0);
        chk("mid_rst_cb_valid", bus.cb_valid, 0);
        chk("mid_rst_cb_dy", bus.cb_dy, 0);
        chk("mid_rst_m_valid", bus.m_valid, 0);
        chk("mid_rst_m_bin", bus.m_bin, 0);
        chk("mid_rst_m_last", bus.m_last, 0);
        chk("mid_rst_err_bin", bus.err_bin, 0);
        #20;
        arest_n = 1'b1;
        @(posedge aclk); #1;
        chk("mid_rst_s_ready_up", bus.s_ready, 1);
        run_vec(vecs[0], -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
